// File: rtl/pipeline_stall_ctrl.sv
// Turns hazard-unit load-use / branch stall requests into PC and pipeline latch
// controls, with one-cycle service acknowledges, a stall counter and a branch timeout.
module pipeline_stall_ctrl #(
  parameter int LU_STALL_CYCLES = 2,
  parameter int JU_MAX_CYCLES   = 4,
  parameter int CNT_W           = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load_use_req,
  input  logic             jump_use_req,
  input  logic             ihit,
  input  logic             dmem_busy,
  input  logic             branch_resolved,
  input  logic             branch_taken,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             lu_done,
  output logic             ju_done,
  output logic             ju_timeout,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] LU_HOLD = 2'd1;
  localparam logic [1:0] JU_HOLD = 2'd2;

  localparam logic [3:0] LU_INIT = 4'(LU_STALL_CYCLES - 1);
  localparam logic [3:0] JU_INIT = 4'(JU_MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0] state, state_nxt;
  logic [3:0] counter, counter_nxt;
  logic       lu_done_nxt, ju_done_nxt, timeout_set;
  logic       req_mask;

  // A done pulse masks requests for one cycle because the hazard unit's
  // registered request only drops a cycle after it sees the acknowledge.
  assign req_mask = lu_done | ju_done;

  always_comb begin
    state_nxt   = state;
    counter_nxt = counter;
    lu_done_nxt = 1'b0;
    ju_done_nxt = 1'b0;
    timeout_set = 1'b0;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;

    if (!dmem_busy) begin
      case (state)
        IDLE: begin
          // The request cycle already behaves as the first stall cycle.
          if (load_use_req && !req_mask) begin
            idex_flush = 1'b1;
            if (ihit && LU_INIT == 4'd0) begin
              lu_done_nxt = 1'b1;
            end else begin
              state_nxt   = LU_HOLD;
              counter_nxt = ihit ? LU_INIT - 4'd1 : LU_INIT;
            end
          end else if (jump_use_req && !req_mask) begin
            idex_flush = 1'b1;
            if (ihit && JU_INIT == 4'd0) begin
              timeout_set = 1'b1;
              ju_done_nxt = 1'b1;
            end else begin
              state_nxt   = JU_HOLD;
              counter_nxt = ihit ? JU_INIT - 4'd1 : JU_INIT;
            end
          end else begin
            pc_en   = ihit;
            ifid_en = ihit;
          end
        end

        LU_HOLD: begin
          idex_flush = 1'b1;
          if (ihit) begin
            if (counter == 4'd0) begin
              state_nxt   = IDLE;
              lu_done_nxt = 1'b1;
            end else begin
              counter_nxt = counter - 4'd1;
            end
          end
        end

        JU_HOLD: begin
          if (branch_resolved) begin
            pc_en       = 1'b1;
            ifid_flush  = branch_taken;
            ifid_en     = !branch_taken;
            state_nxt   = IDLE;
            ju_done_nxt = 1'b1;
          end else begin
            idex_flush = 1'b1;
            if (ihit) begin
              if (counter == 4'd0) begin
                timeout_set = 1'b1;
                state_nxt   = IDLE;
                ju_done_nxt = 1'b1;
              end else begin
                counter_nxt = counter - 4'd1;
              end
            end
          end
        end

        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      counter     <= 4'd0;
      lu_done     <= 1'b0;
      ju_done     <= 1'b0;
      ju_timeout  <= 1'b0;
      stall_count <= '0;
    end else begin
      state   <= state_nxt;
      counter <= counter_nxt;
      lu_done <= lu_done_nxt;
      ju_done <= ju_done_nxt;
      if (timeout_set) ju_timeout <= 1'b1;
      // idex_flush is already forced low while dmem_busy freezes the pipeline.
      if (idex_flush && ihit && stall_count != CNT_MAX)
        stall_count <= stall_count + CNT_ONE;
    end
  end

endmodule
